// File: rtl/ppu_nametable_write_arbiter.sv
// rtl/ppu_nametable_write_arbiter.sv - name-table write port shared by a CPU write FIFO and a fill engine
// Optional build macro NT_VBLANK_ONLY_EN restricts grants to vblank cycles.
module ppu_nametable_write_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int NT_SIZE    = 4800,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk100mhz,
    input  logic              rst,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W-1:0] fill_len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    input  logic              vblank,
    output logic              nameTableWriteEnable,
    output logic [ADDR_W-1:0] nameTableWriteAddr,
    output logic [DATA_W-1:0] nameTableWriteData
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W:0]   NT_SIZE_X = (ADDR_W+1)'(NT_SIZE);
    localparam logic [ADDR_W-1:0] NT_SIZE_A = ADDR_W'(NT_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} fill_state_t;

    fill_state_t state, state_n;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [ADDR_W-1:0] f_base, f_len, f_offset, f_addr;
    logic [DATA_W-1:0] f_value;
    logic              f_addr_vld;
    logic              prefer_fill;

    logic              grant_ok, cpu_req, fill_req, grant_cpu, grant_fill;
    logic              push, fill_last, start_reject;
    logic [ADDR_W-1:0] len_eff, off_sel;
    logic [ADDR_W:0]   addr_sum, addr_wrap;

`ifdef NT_VBLANK_ONLY_EN
    assign grant_ok = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign grant_ok      = 1'b1;
`endif

    assign cpu_ready    = (count != CNT_W'(FIFO_DEPTH));
    assign push         = cpu_valid && cpu_ready;
    assign cpu_req      = (count != '0);
    assign fill_req     = (state == S_FILL) && f_addr_vld;
    assign len_eff      = (fill_len >= NT_SIZE_A) ? NT_SIZE_A : fill_len;
    assign start_reject = ({1'b0, fill_base} >= NT_SIZE_X) || (len_eff == '0);
    assign fill_last    = grant_fill && (f_offset == f_len - ADDR_W'(1));

    // Next fill address is precomputed so the output register sees a plain mux.
    assign off_sel   = grant_fill ? f_offset + ADDR_W'(1) : f_offset;
    assign addr_sum  = {1'b0, f_base} + {1'b0, off_sel};
    assign addr_wrap = (addr_sum >= NT_SIZE_X) ? addr_sum - NT_SIZE_X : addr_sum;

    always_comb begin
        grant_cpu  = 1'b0;
        grant_fill = 1'b0;
        if (grant_ok) begin
            if (cpu_req && fill_req) begin
                grant_fill = prefer_fill;
                grant_cpu  = !prefer_fill;
            end else begin
                grant_cpu  = cpu_req;
                grant_fill = fill_req;
            end
        end
    end

    always_comb begin
        state_n   = state;
        fill_busy = (state == S_FILL);
        fill_done = (state == S_DONE);
        case (state)
            S_IDLE: if (fill_start) state_n = start_reject ? S_DONE : S_FILL;
            S_FILL: if (fill_last) state_n = S_DONE;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk100mhz or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            f_base      <= '0;
            f_len       <= '0;
            f_offset    <= '0;
            f_addr      <= '0;
            f_value     <= '0;
            f_addr_vld  <= 1'b0;
            prefer_fill <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && fill_start) begin
                f_base     <= fill_base;
                f_len      <= len_eff;
                f_value    <= fill_value;
                f_offset   <= '0;
                f_addr_vld <= 1'b0;
            end else if (state == S_FILL) begin
                f_addr     <= addr_wrap[ADDR_W-1:0];
                f_addr_vld <= 1'b1;
                if (grant_fill) f_offset <= f_offset + ADDR_W'(1);
            end
            if (grant_cpu)       prefer_fill <= 1'b1;
            else if (grant_fill) prefer_fill <= 1'b0;
        end
    end

    always_ff @(posedge clk100mhz) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cpu_addr;
            fifo_data[wr_ptr] <= cpu_data;
        end
    end

    always_ff @(posedge clk100mhz or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)      wr_ptr <= wr_ptr + PTR_W'(1);
            if (grant_cpu) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, grant_cpu})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Out-of-range CPU entries consume their grant but never strobe.
    always_ff @(posedge clk100mhz or posedge rst) begin
        if (rst) begin
            nameTableWriteEnable <= 1'b0;
            nameTableWriteAddr   <= '0;
            nameTableWriteData   <= '0;
        end else if (grant_cpu) begin
            nameTableWriteEnable <= ({1'b0, fifo_addr[rd_ptr]} < NT_SIZE_X);
            if ({1'b0, fifo_addr[rd_ptr]} < NT_SIZE_X) begin
                nameTableWriteAddr <= fifo_addr[rd_ptr];
                nameTableWriteData <= fifo_data[rd_ptr];
            end
        end else if (grant_fill) begin
            nameTableWriteEnable <= 1'b1;
            nameTableWriteAddr   <= f_addr;
            nameTableWriteData   <= f_value;
        end else begin
            nameTableWriteEnable <= 1'b0;
        end
    end
endmodule
